mcu_ctrl: RTL and testbench

- Top-level playback control unit for the music player.
- Turns user button events (play/pause, next) and the player's end-of-song indication into three outputs:
  - a play-enable level;
  - a current song index;
  - a one-cycle player-reset pulse.
- Sits between the debounced/one-pulsed button front end and the note player / song ROM.

---
 rtl/mcu_ctrl_if.sv | 51 +++++
 rtl/mcu_ctrl.sv | 75 +++++++
 tb/tb_mcu_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcu_ctrl_if
//
// Purpose:
//   Bundles the playback-control signals that run between the button front
//   end, the note player and the playback controller.
//
// Signals:
//   play_button  - play/pause request, one-cycle pulse
//   next_button  - skip-to-next-song request, one-cycle pulse
//   song_done    - player reports the end of the current song, one-cycle pulse
//   play         - high while the player should advance through notes
//   reset_player - one-cycle pulse, restart the player at note 0
//   song         - current song index, SONG_BITS wide
//
// Modports:
//   master - the surroundings: drives the events and observes the controls
//   slave  - the controller: receives the events and drives the controls
// ---------------------------------------------------------------------------
interface mcu_ctrl_if #(
    parameter int SONG_BITS = 2
);

    logic                 play_button;
    logic                 next_button;
    logic                 song_done;
    logic                 play;
    logic                 reset_player;
    logic [SONG_BITS-1:0] song;

    // The side that generates the events and consumes the playback controls.
    modport master (
        output play_button,
        output next_button,
        output song_done,
        input  play,
        input  reset_player,
        input  song
    );

    // The playback controller itself.
    modport slave (
        input  play_button,
        input  next_button,
        input  song_done,
        output play,
        output reset_player,
        output song
    );

endinterface

// File: rtl/mcu_ctrl.sv
// ---------------------------------------------------------------------------
// mcu_ctrl
//
// Purpose:
//   Playback control unit for the music player. Turns play/pause and next
//   button events, plus the player's end-of-song pulse, into a play-enable
//   level, a current song index and a one-cycle player-restart pulse.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - synchronous, active-high reset
//   bus   - mcu_ctrl_if.slave
//             in : play_button, next_button, song_done (one-cycle pulses)
//             out: play, reset_player, song (all registered)
//
// Parameters:
//   SONG_BITS - width of the song index; the index wraps modulo 2**SONG_BITS
// ---------------------------------------------------------------------------
module mcu_ctrl #(
    parameter int SONG_BITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    mcu_ctrl_if.slave    bus
);

    typedef enum logic {
        PAUSED  = 1'b0,
        PLAYING = 1'b1
    } state_t;

    state_t               state;
    logic [SONG_BITS-1:0] song_q;
    logic                 reset_player_q;

    // A song change happens on a next request in either state, or when the
    // player finishes a song while it is actually playing. An end-of-song
    // pulse seen while paused is stale and must not skip a song. Both sources
    // collapse into a single request, so they advance the index only once
    // even when they arrive in the same cycle.
    logic advance;

    assign advance = bus.next_button || (bus.song_done && (state == PLAYING));

    // Playback state machine and song register.
    // A song change always lands in PAUSED and pulses reset_player so the
    // player restarts at note 0 of the new song; a play/pause request that
    // arrives together with a song change is deliberately dropped. A lone
    // play/pause request only toggles the state and leaves the note position
    // alone, so playback resumes mid-song. The song index relies on natural
    // unsigned overflow to wrap from the last song back to song 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= PAUSED;
            song_q         <= '0;
            reset_player_q <= 1'b1;
        end else if (advance) begin
            state          <= PAUSED;
            song_q         <= song_q + SONG_BITS'(1);
            reset_player_q <= 1'b1;
        end else if (bus.play_button) begin
            state          <= (state == PLAYING) ? PAUSED : PLAYING;
            reset_player_q <= 1'b0;
        end else begin
            reset_player_q <= 1'b0;
        end
    end

    // The enum encodes PLAYING as 1, so play is the state register itself
    // and stays free of any decode logic.
    assign bus.play         = (state == PLAYING);
    assign bus.song         = song_q;
    assign bus.reset_player = reset_player_q;

endmodule

// File: tb/tb_mcu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcu_ctrl
//
// Purpose:
//   Self-checking bench for mcu_ctrl. A behavioural model of the playback
//   rules runs alongside the design and is compared every cycle; directed
//   vectors with hand-computed expectations pin both design and model.
// ---------------------------------------------------------------------------
module tb_mcu_ctrl;

    localparam int SONG_BITS = 2;
    localparam int NUM_SONGS = 1 << SONG_BITS;

    logic clk;
    logic reset;

    mcu_ctrl_if #(.SONG_BITS(SONG_BITS)) bus ();

    mcu_ctrl #(.SONG_BITS(SONG_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Model state: what the outputs must be after the most recent edge.
    bit modelValid = 0;
    bit modelPlay  = 0;
    int modelSong  = 0;
    bit modelReset = 0;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: reset wins; otherwise any request to move on (next
    // always, end-of-song only while playing) means next song, paused, restart
    // pulse; otherwise a play request flips playing/paused.
    always @(posedge clk) begin
        bit moveOn;
        moveOn = bus.next_button || (bus.song_done && modelPlay);
        if (reset) begin
            modelPlay  = 0;
            modelSong  = 0;
            modelReset = 1;
            modelValid = 1;
        end else if (moveOn) begin
            modelPlay  = 0;
            modelSong  = (modelSong + 1) % NUM_SONGS;
            modelReset = 1;
        end else begin
            if (bus.play_button) modelPlay = !modelPlay;
            modelReset = 0;
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checks++;
            if (bus.play !== modelPlay)
                $display("[TB] FAIL model.play t=%0t actual=%0b required=%0b", $time, bus.play, modelPlay);
            else
                passes++;
            checks++;
            if (int'(bus.song) != modelSong || $isunknown(bus.song))
                $display("[TB] FAIL model.song t=%0t actual=%0d required=%0d", $time, bus.song, modelSong);
            else
                passes++;
            checks++;
            if (bus.reset_player !== modelReset)
                $display("[TB] FAIL model.reset_player t=%0t actual=%0b required=%0b", $time, bus.reset_player, modelReset);
            else
                passes++;
        end
    end

    // Drive one cycle of inputs: set after the falling edge, hold through the
    // rising edge, then clear so every event is a single-cycle pulse.
    task automatic applyStimulus(input logic rst, input logic pb, input logic nb, input logic sd);
        @(negedge clk);
        reset           = rst;
        bus.play_button = pb;
        bus.next_button = nb;
        bus.song_done   = sd;
        @(posedge clk);
        #2;
        reset           = 1'b0;
        bus.play_button = 1'b0;
        bus.next_button = 1'b0;
        bus.song_done   = 1'b0;
    endtask

    // Compare outputs against hand-computed values, sampled 2 units after
    // the rising edge.
    task automatic checkOutput(input string name, input logic expPlay, input int expSong, input logic expReset);
        checks++;
        if (bus.play !== expPlay)
            $display("[TB] FAIL %s.play actual=%0b required=%0b", name, bus.play, expPlay);
        else
            passes++;
        checks++;
        if (int'(bus.song) != expSong || $isunknown(bus.song))
            $display("[TB] FAIL %s.song actual=%0d required=%0d", name, bus.song, expSong);
        else
            passes++;
        checks++;
        if (bus.reset_player !== expReset)
            $display("[TB] FAIL %s.reset_player actual=%0b required=%0b", name, bus.reset_player, expReset);
        else
            passes++;
    endtask

    initial begin
        reset           = 1'b0;
        bus.play_button = 1'b0;
        bus.next_button = 1'b0;
        bus.song_done   = 1'b0;

        // Reset held two cycles, then released.
        applyStimulus(1, 0, 0, 0); checkOutput("reset0", 0, 0, 1);
        applyStimulus(1, 0, 0, 0); checkOutput("reset1", 0, 0, 1);
        applyStimulus(0, 0, 0, 0); checkOutput("released", 0, 0, 0);

        // Three play pulses, three cycles apart.
        applyStimulus(0, 1, 0, 0); checkOutput("play1", 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("play1_hold", 1, 0, 0);
        applyStimulus(0, 1, 0, 0); checkOutput("play2", 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("play2_hold", 0, 0, 0);
        applyStimulus(0, 1, 0, 0); checkOutput("play3", 1, 0, 0);

        // Next while playing song 0, then resume.
        applyStimulus(0, 0, 1, 0); checkOutput("next_s1", 0, 1, 1);
        applyStimulus(0, 0, 0, 0); checkOutput("next_s1_idle", 0, 1, 0);
        applyStimulus(0, 1, 0, 0); checkOutput("resume_s1", 1, 1, 0);

        // End of song while playing, then a stale one while paused.
        applyStimulus(0, 0, 0, 1); checkOutput("done_s2", 0, 2, 1);
        applyStimulus(0, 0, 0, 0); checkOutput("done_s2_idle", 0, 2, 0);
        applyStimulus(0, 0, 0, 1); checkOutput("done_paused", 0, 2, 0);

        // Two nexts from song 2 paused: 3, then wrap to 0.
        applyStimulus(0, 0, 1, 0); checkOutput("next_s3", 0, 3, 1);
        applyStimulus(0, 0, 1, 0); checkOutput("next_wrap", 0, 0, 1);
        applyStimulus(0, 0, 0, 0); checkOutput("wrap_idle", 0, 0, 0);

        // Next together with play while playing song 0.
        applyStimulus(0, 1, 0, 0); checkOutput("play_s0", 1, 0, 0);
        applyStimulus(0, 1, 1, 0); checkOutput("next_play", 0, 1, 1);

        // Next together with song_done, paused and playing.
        applyStimulus(0, 0, 1, 1); checkOutput("next_done_paused", 0, 2, 1);
        applyStimulus(0, 1, 0, 0); checkOutput("play_s2", 1, 2, 0);
        applyStimulus(0, 0, 1, 1); checkOutput("next_done_playing", 0, 3, 1);

        // Reset while playing song 3, with other inputs active.
        applyStimulus(0, 1, 0, 0); checkOutput("play_s3", 1, 3, 0);
        applyStimulus(1, 1, 1, 1); checkOutput("reset_mid", 0, 0, 1);
        applyStimulus(0, 0, 0, 0); checkOutput("reset_mid_rel", 0, 0, 0);

        // song_done together with play while playing.
        applyStimulus(0, 1, 0, 0); checkOutput("play_again", 1, 0, 0);
        applyStimulus(0, 1, 0, 1); checkOutput("done_play", 0, 1, 1);

        // Pseudo-random event mix, checked by the model alone.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end
        applyStimulus(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
